// File: rtl/counter_pkg.sv
// Shared types and default widths for the modulo up/down counter.
// No logic; compile-time definitions only.
// No flow control; consumed by counter_step_calc and counter_modn_updown.
package counter_pkg;

    typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;
    typedef enum logic {CNT_UP, CNT_DOWN} cnt_dir_e;

    localparam int CNT_N_DEF      = 8;
    localparam int CNT_STEP_W_DEF = 4;

endpackage

// File: rtl/counter_step_calc.sv
// Next-count computation for one enabled step: bound guard, wrap/saturate, event flag.
// Latency: purely combinational.
// No flow control; the caller decides when the result is taken.
module counter_step_calc
    import counter_pkg::*;
#(
    parameter int N      = CNT_N_DEF,
    parameter int STEP_W = CNT_STEP_W_DEF
) (
    input  logic [N-1:0]      count,
    input  logic [N-1:0]      limit,
    input  logic [STEP_W-1:0] step,
    input  cnt_dir_e          dir,
    input  cnt_mode_e         mode,
    output logic [N-1:0]      next_count,
    output logic              evt
);

    // One extra bit so limit + 1 and count + step never overflow at limit = 2^N-1.
    logic [N:0] cnt_x;
    logic [N:0] lim_x;
    logic [N:0] lim1;
    logic [N:0] step_x;
    logic [N:0] sum;

    assign cnt_x  = {1'b0, count};
    assign lim_x  = {1'b0, limit};
    assign lim1   = lim_x + (N+1)'(1);
    assign step_x = (N+1)'(step);
    assign sum    = cnt_x + step_x;

    // Pick next value: out-of-range guard, zero step, then direction-specific bound handling.
    always_comb begin
        next_count = count;
        evt        = 1'b0;
        if (cnt_x > lim_x) begin
            // limit was lowered under us: snap to the new bound quietly
            next_count = limit;
        end else if (step_x == '0) begin
            next_count = count;
        end else if (dir == CNT_UP) begin
            if (sum <= lim_x) begin
                next_count = sum[N-1:0];
            end else begin
                evt = 1'b1;
                if (mode == CNT_SAT || step_x > lim1) begin
                    next_count = limit;
                end else begin
                    // sum < 2*(limit+1) here, so one subtraction lands in range
                    next_count = N'(sum - lim1);
                end
            end
        end else begin
            if (step_x <= cnt_x) begin
                next_count = N'(cnt_x - step_x);
            end else begin
                evt = 1'b1;
                if (mode == CNT_SAT || step_x > lim1) begin
                    next_count = '0;
                end else begin
                    next_count = N'(cnt_x + lim1 - step_x);
                end
            end
        end
    end

endmodule

// File: rtl/counter_modn_updown.sv
// Modulo-limit up/down counter with load, programmable step, wrap/saturate and bound pulse.
// Latency: count/bound_evt registered, one cycle after the qualifying edge; flags combinational.
// No backpressure; optional match port (COUNTER_MATCH_EN) adds registered match_evt pulse.
module counter_modn_updown
    import counter_pkg::*;
#(
    parameter int N      = CNT_N_DEF,
    parameter int STEP_W = CNT_STEP_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              load,
    input  logic              dec,
    input  logic              sat_mode,
    input  logic [N-1:0]      load_value,
    input  logic [N-1:0]      limit,
    input  logic [STEP_W-1:0] step,
`ifdef COUNTER_MATCH_EN
    input  logic [N-1:0]      match_value,
    output logic              match_evt,
`endif
    output logic [N-1:0]      count,
    output logic              at_limit,
    output logic              at_zero,
    output logic              bound_evt
);

    cnt_dir_e     dir;
    cnt_mode_e    mode;
    logic [N-1:0] step_next;
    logic         step_evt;
    logic [N-1:0] load_clamped;

    assign dir          = dec ? CNT_DOWN : CNT_UP;
    assign mode         = sat_mode ? CNT_SAT : CNT_WRAP;
    assign load_clamped = (load_value > limit) ? limit : load_value;

    counter_step_calc #(
        .N      (N),
        .STEP_W (STEP_W)
    ) u_step_calc (
        .count      (count),
        .limit      (limit),
        .step       (step),
        .dir        (dir),
        .mode       (mode),
        .next_count (step_next),
        .evt        (step_evt)
    );

    // Count register with reset > load > enable > hold priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            count     <= '0;
            bound_evt <= 1'b0;
        end else if (load) begin
            count     <= load_clamped;
            bound_evt <= 1'b0;
        end else if (enable) begin
            count     <= step_next;
            bound_evt <= step_evt;
        end else begin
            bound_evt <= 1'b0;
        end
    end

`ifdef COUNTER_MATCH_EN
    // Match pulse only for updates caused by a load or an enabled step.
    always_ff @(posedge clock) begin
        if (reset) begin
            match_evt <= 1'b0;
        end else if (load) begin
            match_evt <= (load_clamped == match_value);
        end else if (enable) begin
            match_evt <= (step_next == match_value);
        end else begin
            match_evt <= 1'b0;
        end
    end
`endif

    assign at_limit = (count == limit);
    assign at_zero  = (count == '0);

endmodule

// File: tb/tb_counter_modn_updown.sv
// Self-checking bench for counter_modn_updown: directed scenarios then random traffic.
// Reference model uses plain integer arithmetic on the counting rules.
// Inputs driven 1ns after the rising edge, outputs compared at the same point.
module tb_counter_modn_updown;

    localparam int N      = 8;
    localparam int STEP_W = 4;

    logic              clock = 1'b0;
    logic              reset, enable, load, dec, sat_mode;
    logic [N-1:0]      load_value, limit;
    logic [STEP_W-1:0] step;
    logic [N-1:0]      count;
    logic              at_limit, at_zero, bound_evt;
`ifdef COUNTER_MATCH_EN
    logic [N-1:0]      match_value = 8'd6;
    logic              match_evt;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    int m_count = 0;
    int m_evt   = 0;
    int m_match = 0;

    always #5 clock = ~clock;

    counter_modn_updown #(.N(N), .STEP_W(STEP_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .dec        (dec),
        .sat_mode   (sat_mode),
        .load_value (load_value),
        .limit      (limit),
        .step       (step),
`ifdef COUNTER_MATCH_EN
        .match_value(match_value),
        .match_evt  (match_evt),
`endif
        .count      (count),
        .at_limit   (at_limit),
        .at_zero    (at_zero),
        .bound_evt  (bound_evt)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Model of one clock edge, applied to integer state.
    task automatic model_edge(input int r, l, e, d, s, lv, lim, st);
        int c;
        int ev;
        c  = m_count;
        ev = 0;
        if (r != 0) begin
            c = 0;
        end else if (l != 0) begin
            c = (lv > lim) ? lim : lv;
        end else if (e != 0) begin
            if (c > lim) begin
                c = lim;
            end else if (st == 0) begin
                c = c;
            end else if (d == 0) begin
                if (c + st <= lim) begin
                    c = c + st;
                end else begin
                    ev = 1;
                    c  = (s != 0 || st > lim + 1) ? lim : (c + st) % (lim + 1);
                end
            end else begin
                if (st <= c) begin
                    c = c - st;
                end else begin
                    ev = 1;
                    c  = (s != 0 || st > lim + 1) ? 0 : c - st + lim + 1;
                end
            end
        end
`ifdef COUNTER_MATCH_EN
        m_match = (r == 0 && (l != 0 || e != 0) && c == int'(match_value)) ? 1 : 0;
`endif
        m_count = c;
        m_evt   = ev;
    endtask

    task automatic apply(input logic r, l, e, d, s, input logic [N-1:0] lv, lim,
                         input logic [STEP_W-1:0] st);
        reset = r; load = l; enable = e; dec = d; sat_mode = s;
        load_value = lv; limit = lim; step = st;
        model_edge(int'(r), int'(l), int'(e), int'(d), int'(s), int'(lv), int'(lim), int'(st));
        @(posedge clock);
        #1;
        chk("count", int'(count), m_count);
        chk("bound_evt", int'(bound_evt), m_evt);
        chk("at_limit", int'(at_limit), (m_count == int'(lim)) ? 1 : 0);
        chk("at_zero", int'(at_zero), (m_count == 0) ? 1 : 0);
`ifdef COUNTER_MATCH_EN
        chk("match_evt", int'(match_evt), m_match);
`endif
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; enable = 1'b0; dec = 1'b0; sat_mode = 1'b0;
        load_value = '0; limit = 8'd9; step = '0;
        #1;

        // reset state
        apply(1, 0, 0, 0, 0, 0, 9, 0);
        chk("rst_count", int'(count), 0);

        // reset mid-count
        apply(0, 1, 0, 0, 0, 5, 9, 1);
        apply(1, 0, 1, 0, 0, 0, 9, 1);
        chk("rst_mid", int'(count), 0);

        // up wrap: 8 + 3 with limit 9 -> 1, pulse; then 4, no pulse
        apply(0, 1, 0, 0, 0, 8, 9, 3);
        apply(0, 0, 1, 0, 0, 0, 9, 3);
        chk("wrap_cnt", int'(count), 1);
        chk("wrap_evt", int'(bound_evt), 1);
        apply(0, 0, 1, 0, 0, 0, 9, 3);
        chk("wrap_next", int'(count), 4);

        // down saturate, repeated pinning keeps pulsing
        apply(0, 1, 0, 0, 0, 2, 9, 4);
        apply(0, 0, 1, 1, 1, 0, 9, 4);
        chk("dsat_cnt", int'(count), 0);
        apply(0, 0, 1, 1, 1, 0, 9, 4);
        chk("dsat_evt2", int'(bound_evt), 1);

        // load clamp beats enable
        apply(0, 1, 1, 0, 0, 20, 15, 1);
        chk("clamp_cnt", int'(count), 15);
        chk("clamp_lim", int'(at_limit), 1);

        // runtime limit drop then wrap from the new bound
        apply(0, 1, 0, 0, 0, 12, 15, 1);
        apply(0, 0, 1, 0, 0, 0, 7, 1);
        chk("drop_cnt", int'(count), 7);
        chk("drop_evt", int'(bound_evt), 0);
        apply(0, 0, 1, 0, 0, 0, 7, 1);
        chk("drop_wrap", int'(count), 0);

        // limit 0 and full-range limit
        apply(0, 0, 1, 0, 0, 0, 0, 5);
        apply(0, 1, 0, 0, 0, 250, 255, 15);
        apply(0, 0, 1, 0, 0, 0, 255, 15);
        chk("full_wrap", int'(count), 9);
        apply(0, 0, 1, 1, 0, 0, 255, 15);
        apply(0, 0, 1, 1, 0, 0, 255, 0);

`ifdef COUNTER_MATCH_EN
        // match pulses once on reaching 6, not while held there
        apply(0, 1, 0, 0, 0, 0, 9, 2);
        apply(0, 0, 1, 0, 0, 0, 9, 2);
        apply(0, 0, 1, 0, 0, 0, 9, 2);
        apply(0, 0, 1, 0, 0, 0, 9, 2);
        chk("match_hit", int'(match_evt), 1);
        apply(0, 0, 0, 0, 0, 0, 9, 2);
        chk("match_hold", int'(match_evt), 0);
`endif

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] lim;
            int sel;
            sel = int'($urandom_range(0, 19));
            if (sel < 4)       lim = 8'hFF;
            else if (sel == 4) lim = 8'h00;
            else if (i % 40 < 20) lim = 8'd9;
            else               lim = 8'($urandom_range(1, 30));
            apply(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)),
                  lim,
                  4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
